point_check_scheduler: RTL and testbench

//  Sequences wall-corner points of one maze row through the projection + point-validity pipeline.

---
 rtl/maze_render_pkg.sv | 19 +
 rtl/point_fifo.sv | 62 ++++++
 rtl/point_check_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_point_check_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_render_pkg.sv
// Shared types and sizing for the maze row point-check path.
package maze_render_pkg;

  localparam int NUM_WALLS  = 5;
  localparam int CORNERS    = 4;
  localparam int TAG_W      = 10;
  localparam int WALL_IDX_W = 3;
  localparam int CORNER_W   = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} sched_state_t;

  typedef struct packed {
    logic signed [TAG_W-1:0] p;
    logic signed [TAG_W-1:0] x;
    logic signed [TAG_W-1:0] y;
    logic signed [TAG_W-1:0] z;
  } point_t;

endpackage

// File: rtl/point_fifo.sv
// First-word-fall-through FIFO of point_t; head visible the cycle after push.
// Push while full is accepted only together with a pop.
module point_fifo
  import maze_render_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  point_t                   push_dat,
  input  logic                     pop,
  output point_t                   head,
  output logic                     head_vld,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;
  point_t        mem_q [DEPTH];

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is qualified by head_vld.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head     = mem_q[rd_ptr_q];
  assign head_vld = (count_q != '0);
  assign count    = count_q;

endmodule

// File: rtl/point_check_scheduler.sv
// Walks one maze row's wall corners into the check pipeline under credit control, buffering
// valid points for the rasteriser. Optional counters: define POINT_SCHED_STATS_EN.
module point_check_scheduler
  import maze_render_pkg::*;
#(
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_WALLS-1:0]    wall,
  output logic                    busy,
  output logic                    done,
  output logic                    iss_valid,
  output logic [TAG_W-1:0]        iss_p,
  output logic [WALL_IDX_W-1:0]   iss_wall,
  output logic [CORNER_W-1:0]     iss_corner,
  input  logic                    ret_en,
  input  logic [TAG_W-1:0]        ret_p,
  input  logic signed [TAG_W-1:0] ret_x,
  input  logic signed [TAG_W-1:0] ret_y,
  input  logic signed [TAG_W-1:0] ret_z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TAG_W-1:0]        out_p,
  output logic signed [TAG_W-1:0] out_x,
  output logic signed [TAG_W-1:0] out_y,
  output logic signed [TAG_W-1:0] out_z,
  output logic [5:0]              valid_count
`ifdef POINT_SCHED_STATS_EN
  ,
  output logic [5:0]              reject_count,
  output logic [7:0]              stall_count
`endif
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int CRW = $clog2(FIFO_DEPTH) + 2;

  sched_state_t          state_q, state_d;
  logic [NUM_WALLS-1:0]  wall_q, wall_d;
  logic [WALL_IDX_W-1:0] cur_wall_q, cur_wall_d;
  logic [CORNER_W-1:0]   cur_corner_q, cur_corner_d;
  logic [PIPE_LAT-1:0]   infl_q, infl_d;
  logic [5:0]            valid_count_q, valid_count_d;

  logic [CRW-1:0]        inflight, credit;
  logic [FCW-1:0]        fifo_count;
  logic                  fifo_vld, wall_bit, issue, ret_hit, push, pop, accept_start;
  point_t                push_pt, head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++) inflight = inflight + CRW'(infl_q[i]);
  end

  // Slots already in flight are reserved so a late return always finds FIFO room.
  assign credit       = CRW'(FIFO_DEPTH) - CRW'(fifo_count) - inflight;
  assign wall_bit     = wall_q[cur_wall_q];
  assign issue        = (state_q == ISSUE) && wall_bit && (credit != '0);
  assign ret_hit      = infl_q[PIPE_LAT-1];
  assign push         = ret_hit && ret_en;
  assign pop          = out_valid && out_ready;
  assign accept_start = (state_q == IDLE) && start;

  always_comb begin
    state_d       = state_q;
    wall_d        = wall_q;
    cur_wall_d    = cur_wall_q;
    cur_corner_d  = cur_corner_q;
    valid_count_d = valid_count_q;
    infl_d        = infl_q << 1;
    infl_d[0]     = issue;
    if (push && (valid_count_q != 6'h3f)) valid_count_d = valid_count_q + 6'd1;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = ISSUE;
          wall_d        = wall;
          cur_wall_d    = '0;
          cur_corner_d  = '0;
          valid_count_d = '0;
        end
      end
      ISSUE: begin
        if (!wall_bit || issue) begin
          if (!wall_bit || (cur_corner_q == CORNER_W'(CORNERS-1))) begin
            cur_corner_d = '0;
            if (cur_wall_q == WALL_IDX_W'(NUM_WALLS-1)) state_d = DRAIN;
            else cur_wall_d = cur_wall_q + WALL_IDX_W'(1);
          end else begin
            cur_corner_d = cur_corner_q + CORNER_W'(1);
          end
        end
      end
      DRAIN:   if (inflight == '0) state_d = FLUSH;
      FLUSH:   if (!fifo_vld) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wall_q        <= '0;
      cur_wall_q    <= '0;
      cur_corner_q  <= '0;
      infl_q        <= '0;
      valid_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wall_q        <= wall_d;
      cur_wall_q    <= cur_wall_d;
      cur_corner_q  <= cur_corner_d;
      infl_q        <= infl_d;
      valid_count_q <= valid_count_d;
    end
  end

  always_comb begin
    push_pt.p = ret_p;
    push_pt.x = ret_x;
    push_pt.y = ret_y;
    push_pt.z = ret_z;
  end

  point_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_pt),
    .pop      (pop),
    .head     (head),
    .head_vld (fifo_vld),
    .count    (fifo_count)
  );

  // busy drops in the done cycle so the two never overlap.
  assign done        = (state_q == FLUSH) && !fifo_vld;
  assign busy        = (state_q != IDLE) && !done;
  assign iss_valid   = issue;
  assign iss_wall    = issue ? cur_wall_q : '0;
  assign iss_corner  = issue ? cur_corner_q : '0;
  assign iss_p       = issue ? {{(TAG_W-WALL_IDX_W-CORNER_W){1'b0}}, cur_wall_q, cur_corner_q} : '0;
  assign out_valid   = fifo_vld;
  assign out_p       = fifo_vld ? head.p : '0;
  assign out_x       = fifo_vld ? head.x : '0;
  assign out_y       = fifo_vld ? head.y : '0;
  assign out_z       = fifo_vld ? head.z : '0;
  assign valid_count = valid_count_q;

`ifdef POINT_SCHED_STATS_EN
  logic [5:0] reject_q, reject_d;
  logic [7:0] stall_q, stall_d;

  always_comb begin
    reject_d = reject_q;
    stall_d  = stall_q;
    if (ret_hit && !ret_en && (reject_q != 6'h3f)) reject_d = reject_q + 6'd1;
    if ((state_q == ISSUE) && wall_bit && (credit == '0) && (stall_q != 8'hff))
      stall_d = stall_q + 8'd1;
    if (accept_start) begin
      reject_d = '0;
      stall_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reject_q <= '0;
      stall_q  <= '0;
    end else begin
      reject_q <= reject_d;
      stall_q  <= stall_d;
    end
  end

  assign reject_count = reject_q;
  assign stall_count  = stall_q;
`else
  logic unused_accept;
  assign unused_accept = accept_start;
`endif

endmodule

// File: tb/tb_point_check_scheduler.sv
// Randomized bench for point_check_scheduler with a behavioural pipeline/scoreboard model.
module tb_point_check_scheduler;
  import maze_render_pkg::*;

  localparam int PL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [4:0] wall = '0;
  logic busy, done, iss_valid, out_valid, ret_en;
  logic [9:0] iss_p, out_p, ret_p;
  logic [2:0] iss_wall;
  logic [1:0] iss_corner;
  logic signed [9:0] ret_x, ret_y, ret_z, out_x, out_y, out_z;
  logic [5:0] valid_count;
`ifdef POINT_SCHED_STATS_EN
  logic [5:0] reject_count;
  logic [7:0] stall_count;
`endif

  always #5 clk = ~clk;

  point_check_scheduler #(.PIPE_LAT(PL), .FIFO_DEPTH(8)) dut (
`ifdef POINT_SCHED_STATS_EN
    .reject_count(reject_count),
    .stall_count (stall_count),
`endif
    .clk(clk), .rst(rst), .start(start), .wall(wall), .busy(busy), .done(done),
    .iss_valid(iss_valid), .iss_p(iss_p), .iss_wall(iss_wall), .iss_corner(iss_corner),
    .ret_en(ret_en), .ret_p(ret_p), .ret_x(ret_x), .ret_y(ret_y), .ret_z(ret_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .valid_count(valid_count)
  );

  int checks = 0, errors = 0;
  int done_cnt = 0, busy_cyc = 0, clr_gen = 0, clr_seen = 0, ret_mode = 0;
  logic [14:0] iss_q[$], exp_iss[$];
  logic [39:0] got_q[$], exp_q[$];

  typedef struct packed {bit v; bit live; bit [9:0] p;} slot_t;
  slot_t hist [PL];

  // Pipeline model: returns each issued tag PL cycles later, garbage otherwise.
  always @(negedge clk) begin
    slot_t r;
    logic  en;
    if (clr_gen != clr_seen) begin
      clr_seen = clr_gen;
      iss_q.delete(); got_q.delete(); exp_q.delete();
      done_cnt = 0; busy_cyc = 0;
    end
    if (rst) for (int i = 0; i < PL; i++) hist[i].live = 1'b0;
    r = hist[PL-1];
    if (!rst) begin
      if (iss_valid) iss_q.push_back({iss_wall, iss_corner, iss_p});
      if (out_valid && out_ready) got_q.push_back({out_p, out_x, out_y, out_z});
      if (done) done_cnt++;
      if (busy) busy_cyc++;
    end
    ret_x = 10'($urandom); ret_y = 10'($urandom); ret_z = 10'($urandom);
    if (r.v) begin
      case (ret_mode)
        0:       en = 1'b1;
        1:       en = ~r.p[0];
        default: en = ($urandom_range(0, 3) != 0);
      endcase
      if (!r.live) en = 1'b1;
      ret_en = en;
      ret_p  = r.p;
      if (r.live && en) exp_q.push_back({ret_p, ret_x, ret_y, ret_z});
    end else begin
      ret_en = 1'($urandom);
      ret_p  = 10'($urandom);
    end
    for (int i = PL-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = '{v: (iss_valid === 1'b1) && !rst, live: 1'b1, p: iss_p};
  end

  function automatic void add_iss(input logic [4:0] m);
    for (int w = 0; w < NUM_WALLS; w++)
      if (m[w]) for (int c = 0; c < CORNERS; c++) exp_iss.push_back({3'(w), 2'(c), 10'(w*4+c)});
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    clr_gen++;
    exp_iss.delete();
    tick();
  endtask

  task automatic start_scan(input logic [4:0] m);
    wall = m; start = 1'b1;
    tick();
    start = 1'b0; wall = 5'($urandom);
  endtask

  task automatic wait_done(input int rdy_rand, input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (rdy_rand != 0) out_ready = 1'($urandom);
      tick();
      if (done_cnt >= target) begin ok = 1'b1; break; end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if ({busy, done, iss_valid, out_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, iss_valid, out_valid}); end
    checks++; if ({iss_p, iss_wall, iss_corner} !== 15'b0) begin
      errors++; $display("FAIL reset_iss: got %h want 0", {iss_p, iss_wall, iss_corner}); end
    checks++; if ({out_p, out_x, out_y, out_z} !== 40'b0) begin
      errors++; $display("FAIL reset_out: got %h want 0", {out_p, out_x, out_y, out_z}); end
    checks++; if (valid_count !== 6'd0) begin
      errors++; $display("FAIL reset_vcount: got %0d want 0", valid_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    clear_obs(); ret_mode = 0; out_ready = 1'b1; add_iss(5'b10101);
    start_scan(5'b10101);
    wait_done(0, 1, ok);
    repeat (4) tick();
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no done want done"); end
    checks++; if (iss_q.size() != 12) begin
      errors++; $display("FAIL basic_iss_n: got %0d want 12", iss_q.size()); end
    for (int i = 0; i < iss_q.size() && i < exp_iss.size(); i++) begin
      checks++; if (iss_q[i] !== exp_iss[i]) begin
        errors++; $display("FAIL basic_iss[%0d]: got %h want %h", i, iss_q[i], exp_iss[i]); end
    end
    checks++; if (got_q.size() != 12 || exp_q.size() != 12) begin
      errors++; $display("FAIL basic_out_n: got %0d want 12", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_out[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (valid_count !== 6'd12) begin
      errors++; $display("FAIL basic_vcount: got %0d want 12", valid_count); end
    checks++; if (done_cnt != 1) begin
      errors++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_mask();
    bit ok;
    clear_obs(); ret_mode = 2;
    start_scan(5'b00000);
    wait_done(0, 1, ok);
    repeat (3) tick();
    checks++; if (!ok) begin errors++; $display("FAIL zero_timeout: got no done want done"); end
    checks++; if (iss_q.size() != 0) begin
      errors++; $display("FAIL zero_iss: got %0d want 0", iss_q.size()); end
    checks++; if (busy_cyc != NUM_WALLS + 1) begin
      errors++; $display("FAIL zero_busy: got %0d want %0d", busy_cyc, NUM_WALLS + 1); end
    checks++; if (done_cnt != 1 || valid_count !== 6'd0) begin
      errors++; $display("FAIL zero_done_vc: got %0d/%0d want 1/0", done_cnt, valid_count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_obs(); ret_mode = 0; out_ready = 1'b0; add_iss(5'b11111);
    start_scan(5'b11111);
    repeat (40) tick();
    checks++; if (iss_q.size() != 8) begin
      errors++; $display("FAIL bp_stall_iss: got %0d want 8", iss_q.size()); end
    checks++; if (got_q.size() != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_stall_state: got out=%0d busy=%b want 0/1", got_q.size(), busy); end
    out_ready = 1'b1;
    wait_done(0, 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got no done want done"); end
    checks++; if (iss_q.size() != 20 || got_q.size() != 20) begin
      errors++; $display("FAIL bp_count: got %0d/%0d want 20/20", iss_q.size(), got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i][39:30] !== 10'(i) || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_out[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reject();
    bit ok;
    clear_obs(); ret_mode = 1; out_ready = 1'b1;
    start_scan(5'b00011);
    wait_done(0, 1, ok);
    checks++; if (!ok || got_q.size() != 4) begin
      errors++; $display("FAIL rej_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i][39:30] !== 10'(2*i) || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rej_out[%0d]: got %h want tag %0d", i, got_q[i], 2*i); end
    end
    checks++; if (valid_count !== 6'd4) begin
      errors++; $display("FAIL rej_vcount: got %0d want 4", valid_count); end
`ifdef POINT_SCHED_STATS_EN
    checks++; if (reject_count !== 6'd4) begin
      errors++; $display("FAIL rej_stat: got %0d want 4", reject_count); end
`endif
  endtask

  task automatic test_random();
    bit ok;
    logic [4:0] m;
    for (int n = 0; n < 6; n++) begin
      clear_obs(); ret_mode = 2;
      m = 5'($urandom);
      add_iss(m);
      start_scan(m);
      wait_done(1, 1, ok);
      checks++; if (!ok || iss_q.size() != exp_iss.size()) begin
        errors++; $display("FAIL rnd%0d_iss_n: got %0d want %0d", n, iss_q.size(), exp_iss.size()); end
      for (int i = 0; i < iss_q.size() && i < exp_iss.size(); i++) begin
        checks++; if (iss_q[i] !== exp_iss[i]) begin
          errors++; $display("FAIL rnd%0d_iss[%0d]: got %h want %h", n, i, iss_q[i], exp_iss[i]); end
      end
      checks++; if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd%0d_out_n: got %0d want %0d", n, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rnd%0d_out[%0d]: got %h want %h", n, i, got_q[i], exp_q[i]); end
      end
      checks++; if (valid_count !== 6'(exp_q.size())) begin
        errors++; $display("FAIL rnd%0d_vcount: got %0d want %0d", n, valid_count, exp_q.size()); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [4:0] m;
    clear_obs(); ret_mode = 0; out_ready = 1'b1;
    start_scan(5'b11111);
    for (int i = 0; i < 20 && iss_q.size() < 3; i++) tick();
    checks++; if (iss_q.size() != 3) begin
      errors++; $display("FAIL rstmid_inflight: got %0d want 3", iss_q.size()); end
    rst = 1'b1;
    #1;
    checks++; if ({busy, done, iss_valid, out_valid, iss_p, out_p, valid_count} !== 30'b0) begin
      errors++; $display("FAIL rstmid_outputs: got %h want 0",
                         {busy, done, iss_valid, out_valid, iss_p, out_p, valid_count}); end
    tick();
    rst = 1'b0;
    repeat (8) tick();
    checks++; if (got_q.size() != 0 || out_valid !== 1'b0 || valid_count !== 6'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_quiet: got out=%0d vc=%0d busy=%b want 0/0/0",
                         got_q.size(), valid_count, busy); end
    clear_obs();
    m = 5'($urandom) | 5'b00100;
    add_iss(m);
    start_scan(m);
    wait_done(0, 1, ok);
    checks++; if (!ok || iss_q.size() != exp_iss.size() || got_q.size() != exp_iss.size()) begin
      errors++; $display("FAIL rstmid_rescan_n: got %0d/%0d want %0d", iss_q.size(), got_q.size(), exp_iss.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i] || iss_q[i] !== exp_iss[i]) begin
        errors++; $display("FAIL rstmid_rescan[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_ignore();
    bit ok, seen;
    clear_obs(); ret_mode = 0; out_ready = 1'b1;
    add_iss(5'b00001); add_iss(5'b00110);
    start_scan(5'b00001);
    repeat (2) tick();
    wall = 5'b11111; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL ign_first_done: got no done want done"); end
    start = 1'b1; wall = 5'b00110;
    tick();
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL ign_done_cycle: got busy=%b want 0", busy); end
    tick();
    start = 1'b0; wall = 5'($urandom);
    checks++; if (busy !== 1'b1) begin
      errors++; $display("FAIL ign_next_accept: got busy=%b want 1", busy); end
    wait_done(0, 2, ok);
    repeat (4) tick();
    checks++; if (!ok || done_cnt != 2 || iss_q.size() != exp_iss.size()) begin
      errors++; $display("FAIL ign_totals: got done=%0d iss=%0d want 2/%0d", done_cnt, iss_q.size(), exp_iss.size()); end
    for (int i = 0; i < iss_q.size() && i < exp_iss.size(); i++) begin
      checks++; if (iss_q[i] !== exp_iss[i]) begin
        errors++; $display("FAIL ign_iss[%0d]: got %h want %h", i, iss_q[i], exp_iss[i]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_mask();
    test_backpressure();
    test_reject();
    test_random();
    test_reset_mid();
    test_start_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
